fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64: PC and address width.
REQ-002 SHALL have parameter RESET_PC, default 64'h0: first fetch address after reset.
REQ-003 SHALL have parameter QDEPTH, default 2: instruction queue entries; legal values 2 or 4.
REQ-004 SHALL have port Clk  input  1: single clock, rising edge.
REQ-005 SHALL have port En  input  1: asynchronous active-low reset (0 = reset).
REQ-006 SHALL have port imem_req  output  1: fetch request to instruction memory.
REQ-007 SHALL have port imem_addr  output  XLEN: fetch address.
REQ-008 SHALL have port imem_rvalid  input  1: response valid, exactly 1 cycle after an accepted request.
REQ-009 SHALL have port imem_rdata  input  32: fetched instruction word.
REQ-010 SHALL have port redirect_valid  input  1: taken branch/jump from execute.
REQ-011 SHALL have port redirect_pc  input  XLEN: branch target (pc + imm).
REQ-012 SHALL have port inst_valid  output  1: instruction offered to decode.
REQ-013 SHALL have port inst_ready  input  1: decode accepts.
REQ-014 SHALL have port inst_data  output  32: instruction to decode.
REQ-015 SHALL have port inst_pc  output  XLEN: PC of inst_data.

Function
REQ-016 SHALL keep fetch_pc; each issued request uses imem_addr = fetch_pc, then fetch_pc += 4 (mod 2^XLEN, wrap silently).
REQ-017 SHALL assert imem_req only when queue_count + outstanding < QDEPTH and state is FETCH; outstanding is 0 or 1.
REQ-018 SHALL write imem_rdata with its PC into the queue on imem_rvalid unless the response is marked killed.
REQ-019 SHALL present the queue head registered: inst_valid = queue non-empty; entry written at edge N is visible from cycle N+1.
REQ-020 SHALL pop on inst_valid && inst_ready; inst_data/inst_pc SHALL stay stable while inst_valid && !inst_ready.
REQ-021 SHALL allow push and pop in the same cycle when full; count unchanged.
REQ-022 SHALL implement states RESET_HOLD, FETCH, FLUSH: RESET_HOLD -> FETCH one cycle after En rises; FETCH -> FLUSH on redirect_valid; FLUSH -> FETCH after exactly one cycle.
REQ-023 SHALL on redirect_valid: clear queue at that edge, set fetch_pc = redirect_pc, mark any outstanding response killed, deassert imem_req during FLUSH; first target request issues in the cycle after FLUSH.
REQ-024 SHALL give redirect_valid priority over push, pop and issue in the same cycle; inst_valid is 0 during FLUSH.
REQ-025 SHALL ignore imem_rvalid when outstanding = 0 (no push).
REQ-026 SHALL deliver first instruction: request in cycle 1 after reset release, rvalid cycle 2, inst_valid cycle 3.

Reset
REQ-027 SHALL on En = 0, asynchronously: state = RESET_HOLD, fetch_pc = RESET_PC, queue empty, outstanding = 0, kill = 0, imem_req = 0, imem_addr = RESET_PC, inst_valid = 0, inst_data = 0, inst_pc = 0.
REQ-028 SHALL drop any in-flight response when reset asserts mid-operation; no stale entry after release.

Configuration
REQ-029 SHALL, when FETCH_PERF_EN is defined, add outputs fetch_count (32) counting pops and bubble_count (32) counting cycles with inst_ready && !inst_valid outside RESET_HOLD, both reset to 0 and wrapping at 2^32.
REQ-030 SHALL, without FETCH_PERF_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-031 SHALL place the state encoding (RESET_HOLD/FETCH/FLUSH), instruction width 32 and PC increment 4 in a shared package fetch_pkg.
REQ-032 SHALL implement the queue as sub-module inst_queue (parameterised depth, push/pop/flush, count).

Verification
REQ-033 Reset release, RESET_PC=0, inst_ready=1, imem returns 0x00000013 per request -> imem_addr 0,4,8,...; inst_pc 0 at cycle 3, then one instruction per cycle.
REQ-034 inst_ready=0 for 6 cycles -> queue fills to QDEPTH, imem_req drops, inst_pc held at 0; on ready=1 drains 0,4 in order with no loss or duplicate.
REQ-035 redirect_valid with redirect_pc=0x100 while a request is outstanding -> that response discarded, inst_valid=0 in FLUSH, next imem_addr=0x100, next inst_pc=0x100.
REQ-036 redirect_valid in same cycle as full-queue pop and rvalid -> queue empty, neither entry delivered, fetch restarts at target.
REQ-037 En pulled low mid-stream with outstanding request -> all outputs at reset values immediately; after release first inst_pc = RESET_PC.
REQ-038 FETCH_PERF_EN defined, 10 pops and 3 starved cycles -> fetch_count=10, bubble_count=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch unit: the fetch FSM state
//   encoding, the instruction word width and the sequential PC increment.
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        FETCH      = 2'd1,
        FLUSH      = 2'd2
    } fetch_state_e;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_INC = 4;

endpackage : fetch_pkg

// File: rtl/fetch_unit_inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//   Small circular FIFO holding fetched instruction words and their PCs.
//   The head entry is read straight from the storage registers, so a word
//   written at edge N is visible from cycle N+1. Push and pop may happen in the
//   same cycle, including when full (count unchanged). flush_i empties the
//   queue and overrides push/pop in that cycle.
//
//   Ports
//     clk_i        clock, rising edge
//     rst_ni       asynchronous active-low reset
//     push_i       write wdata_i/wpc_i at the tail
//     pop_i        drop the head entry
//     flush_i      discard all entries
//     wdata_i      instruction word to write
//     wpc_i        PC of the word to write
//     count_o      number of valid entries
//     head_data_o  instruction word at the head
//     head_pc_o    PC at the head
//   DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module inst_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PC_W  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [INST_W-1:0]        wdata_i,
    input  logic [PC_W-1:0]          wpc_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [INST_W-1:0]        head_data_o,
    output logic [PC_W-1:0]          head_pc_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [INST_W-1:0] data_q [DEPTH];
    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              full, empty, do_push, do_pop;

    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        empty   = (count_q == '0);
        do_pop  = pop_i && !empty;
        // A full queue still accepts a push when the head leaves in the same cycle.
        do_push = push_i && (!full || do_pop);

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) begin
                data_q[wr_ptr_q] <= wdata_i;
                pc_q[wr_ptr_q]   <= wpc_i;
            end
        end
    end

    assign count_o     = count_q;
    assign head_data_o = data_q[rd_ptr_q];
    assign head_pc_o   = pc_q[rd_ptr_q];

endmodule : inst_queue

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. Issues sequential fetches from fetch_pc to a
//   fixed 1-cycle-latency instruction memory, buffers the returned words in
//   inst_queue and offers the queue head to decode with a valid/ready
//   handshake. A redirect from execute empties the queue, retargets fetch_pc
//   and spends one FLUSH cycle before fetching the target.
//
//   Parameters
//     XLEN      PC / address width
//     RESET_PC  first fetch address after reset
//     QDEPTH    instruction queue entries (2 or 4)
//
//   Ports
//     Clk             clock, rising edge
//     En              asynchronous active-low reset
//     imem_req        fetch request (accepted whenever asserted)
//     imem_addr       fetch address
//     imem_rvalid     response valid, one cycle after the request
//     imem_rdata      fetched instruction word
//     redirect_valid  taken branch/jump from execute
//     redirect_pc     branch target
//     inst_valid      instruction offered to decode
//     inst_ready      decode accepts
//     inst_data       instruction offered to decode
//     inst_pc         PC of inst_data
//
//   Optional build macro FETCH_PERF_EN adds:
//     fetch_count     number of instructions handed to decode (wraps)
//     bubble_count    cycles decode was ready but starved, outside RESET_HOLD
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic              Clk,
    input  logic              En,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [XLEN-1:0]   inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       bubble_count
`endif
);

    fetch_state_e           state_q, state_d;
    logic [XLEN-1:0]        fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]        req_pc_q, req_pc_d;
    logic                   outst_q, outst_d;
    logic                   kill_q, kill_d;
    logic [$clog2(QDEPTH):0] q_count;
    logic                   redir, issue, push, pop;
    int unsigned            credit;

    always_comb begin
        // Redirects are only honoured while fetching; they pre-empt every
        // other queue/issue action in the same cycle.
        redir      = redirect_valid && (state_q == FETCH);
        credit     = 32'(q_count) + 32'(outst_q);
        issue      = (state_q == FETCH) && !redir && (credit < QDEPTH);
        inst_valid = (state_q != FLUSH) && (q_count != '0);
        pop        = inst_valid && inst_ready && !redir;
        push       = imem_rvalid && outst_q && !kill_q && !redir;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        outst_d    = outst_q;
        kill_d     = kill_q;

        case (state_q)
            RESET_HOLD: state_d = FETCH;
            FETCH:      if (redir) state_d = FLUSH;
            FLUSH:      state_d = FETCH;
            default:    state_d = RESET_HOLD;
        endcase

        if (redir) begin
            fetch_pc_d = redirect_pc;
            // A response still pending past this edge belongs to the old
            // path; it stays outstanding but is dropped on arrival.
            kill_d     = outst_q && !imem_rvalid;
            outst_d    = outst_q && !imem_rvalid;
        end else begin
            if (imem_rvalid && outst_q) begin
                outst_d = 1'b0;
                kill_d  = 1'b0;
            end
            if (issue) begin
                outst_d    = 1'b1;
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
            end
        end
    end

    always_ff @(posedge Clk or negedge En) begin
        if (!En) begin
            state_q    <= RESET_HOLD;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            outst_q    <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            outst_q    <= outst_d;
            kill_q     <= kill_d;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    inst_queue #(
        .DEPTH (QDEPTH),
        .PC_W  (XLEN)
    ) u_queue (
        .clk_i       (Clk),
        .rst_ni      (En),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (redir),
        .wdata_i     (imem_rdata),
        .wpc_i       (req_pc_q),
        .count_o     (q_count),
        .head_data_o (inst_data),
        .head_pc_o   (inst_pc)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, bubble_count_q;

    always_ff @(posedge Clk or negedge En) begin
        if (!En) begin
            fetch_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            if (pop) fetch_count_q <= fetch_count_q + 32'd1;
            if (inst_ready && !inst_valid && (state_q != RESET_HOLD))
                bubble_count_q <= bubble_count_q + 32'd1;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Randomized bench for fetch_unit with a behavioural reference model
//   (instruction queue as a SV queue, outstanding/killed flags, fetch PC) and a
//   1-cycle-latency instruction memory model. Directed phases at the start
//   cover first-fetch latency and queue-full stall; a mid-stream reset is
//   forced while a request is outstanding.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned QDEPTH   = 2;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int unsigned N_ITER   = 700;

    localparam int S_HOLD  = 0;
    localparam int S_FETCH = 1;
    localparam int S_FLUSH = 2;

    logic        Clk;
    logic        En;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .Clk            (Clk),
        .En             (En),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .bubble_count   (bubble_count)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic [63:0] pc;
    } ent_t;

    ent_t        mq[$];
    int          m_st;
    bit          m_outst;
    bit          m_kill;
    logic [63:0] m_pc;
    logic [63:0] m_req_pc;
    int unsigned m_fc;
    int unsigned m_bc;

    bit          e_req, e_valid, m_redir;
    bit          req_seen;
    int          since_rel;
    bit          did_rst;
    bit          prev_redir;
    logic [63:0] prev_target;
    int          after_redir;

    int unsigned n_checks;
    int unsigned n_pass;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_st     = S_HOLD;
        m_outst  = 1'b0;
        m_kill   = 1'b0;
        m_pc     = RESET_PC;
        m_req_pc = '0;
        m_fc     = 0;
        m_bc     = 0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_imem_req"},   imem_req,   1'b0);
        check_eq({pfx, "_imem_addr"},  imem_addr,  RESET_PC);
        check_eq({pfx, "_inst_valid"}, inst_valid, 1'b0);
        check_eq({pfx, "_inst_data"},  inst_data,  32'h0);
        check_eq({pfx, "_inst_pc"},    inst_pc,    64'h0);
`ifdef FETCH_PERF_EN
        check_eq({pfx, "_fetch_count"},  fetch_count,  32'h0);
        check_eq({pfx, "_bubble_count"}, bubble_count, 32'h0);
`endif
    endtask

    task automatic drive_inputs(input int it);
        logic [63:0] tgt;
        imem_rvalid = req_seen;
        imem_rdata  = (it < 20) ? 32'h0000_0013 : $urandom;
        // Stray responses with nothing outstanding must be ignored.
        if (!req_seen && it >= 20 && $urandom_range(0, 7) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end
        if (it < 12)      inst_ready = 1'b1;
        else if (it < 20) inst_ready = 1'b0;
        else              inst_ready = ($urandom_range(0, 3) != 0);

        redirect_valid = 1'b0;
        redirect_pc    = {$urandom, $urandom};
        if (it >= 20 && m_st == S_FETCH && since_rel >= 4) begin
            if ($urandom_range(0, 9) == 0 ||
                (mq.size() == QDEPTH && imem_rvalid && inst_ready && $urandom_range(0, 1) == 0)) begin
                case ($urandom_range(0, 2))
                    0:       tgt = 64'h100;
                    1:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                    default: tgt = {$urandom, $urandom} & ~64'h3;
                endcase
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
            end
        end
    endtask

    task automatic check_step(input int it);
        m_redir = redirect_valid && (m_st == S_FETCH);
        e_req   = (m_st == S_FETCH) && !m_redir && ((mq.size() + int'(m_outst)) < QDEPTH);
        e_valid = (m_st != S_FLUSH) && (mq.size() != 0);
        check_eq("imem_req",   imem_req,   e_req);
        check_eq("imem_addr",  imem_addr,  m_pc);
        check_eq("inst_valid", inst_valid, e_valid);
        if (e_valid) begin
            check_eq("inst_data", inst_data, mq[0].d);
            check_eq("inst_pc",   inst_pc,   mq[0].pc);
        end
`ifdef FETCH_PERF_EN
        check_eq("fetch_count",  fetch_count,  m_fc);
        check_eq("bubble_count", bubble_count, m_bc);
`endif
        if (since_rel == 1) begin
            check_eq("first_req",  imem_req,  1'b1);
            check_eq("first_addr", imem_addr, RESET_PC);
        end
        if (since_rel == 3) begin
            check_eq("first_valid", inst_valid, 1'b1);
            check_eq("first_pc",    inst_pc,    RESET_PC);
        end
        if (it == 19) begin
            check_eq("full_req_off",  imem_req,   1'b0);
            check_eq("full_valid_on", inst_valid, 1'b1);
        end
        if (after_redir == 1) begin
            check_eq("flush_valid", inst_valid, 1'b0);
            check_eq("flush_req",   imem_req,   1'b0);
        end
        if (after_redir == 2 && !redirect_valid) begin
            check_eq("target_req",  imem_req,  1'b1);
            check_eq("target_addr", imem_addr, prev_target);
        end
        req_seen = imem_req;
    endtask

    task automatic model_edge();
        bit   pop;
        ent_t e;
        pop = e_valid && inst_ready && !m_redir;
        if (pop) m_fc++;
        if (inst_ready && !e_valid && m_st != S_HOLD) m_bc++;
        if (m_redir) begin
            mq.delete();
            m_pc    = redirect_pc;
            m_kill  = m_outst && !imem_rvalid;
            m_outst = m_kill;
            m_st    = S_FLUSH;
        end else begin
            if (pop) void'(mq.pop_front());
            if (imem_rvalid && m_outst) begin
                if (!m_kill) begin
                    e.d  = imem_rdata;
                    e.pc = m_req_pc;
                    mq.push_back(e);
                end
                m_outst = 1'b0;
                m_kill  = 1'b0;
            end
            if (e_req) begin
                m_outst  = 1'b1;
                m_req_pc = m_pc;
                m_pc     = m_pc + 64'd4;
            end
            m_st = S_FETCH;
        end
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        En             = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        req_seen       = 1'b0;
        did_rst        = 1'b0;
        after_redir    = 0;
        prev_target    = '0;
        model_reset();

        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        En        = 1'b1;
        since_rel = 0;

        for (int it = 0; it < N_ITER; it++) begin
            drive_inputs(it);
            if (it >= 400 && !did_rst && m_outst) begin
                // Reset lands while a response is arriving; it must be dropped.
                En = 1'b0;
                #1;
                check_reset_outputs("rst_mid");
                model_reset();
                @(posedge Clk);
                #1;
                check_reset_outputs("rst_hold");
                En          = 1'b1;
                since_rel   = 0;
                req_seen    = 1'b0;
                did_rst     = 1'b1;
                after_redir = 0;
                drive_inputs(it);
            end
            #2;
            check_step(it);
            prev_redir = m_redir;
            @(posedge Clk);
            if (En) model_edge();
            since_rel++;
            if (prev_redir) begin
                after_redir = 1;
                prev_target = redirect_pc;
            end else if (after_redir != 0) begin
                after_redir = (after_redir >= 2) ? 0 : after_redir + 1;
            end
            #1;
        end

        check_eq("did_mid_reset", did_rst, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_unit
